ghash_n_blocks_stream: RTL
==========================

Name: ghash_n_blocks_stream

Overview:
- Streaming GHASH accumulator that absorbs N_BLOCKS 128-bit blocks per clock.
- Uses an internally generated H-power table H^1..H^N_BLOCKS, built sequentially after each key update.
- Supports partial final words and appends the lengths block; emits the GHASH value with a one-cycle valid strobe.
- Successor to the fixed two-block GHASH path inside gcm_aes_cipher/decipher; sits between the AES-CTR datapath and tag generation/check.

Parameters:
- NB_BLOCK, 128, GF(2^128) block width (fixed at 128).
- N_BLOCKS, 2, blocks per input word (1..8).
- LOG2_N_BLOCKS, 1, width of the power-table index.
- NB_DATA, N_BLOCKS*NB_BLOCK, input word width.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_h_key  in  NB_BLOCK  hash subkey H; sampled when i_update_key=1.
- i_update_key  in  1  start H-power table rebuild.
- i_valid  in  1  global clock enable; all state holds when 0.
- i_sop  in  1  start of message; clears the accumulator.
- i_data_valid  in  1  i_data holds blocks to absorb.
- i_data  in  NB_DATA  block k at bits [k*128+127 : k*128]; block 0 is first in stream order.
- i_block_mask  in  N_BLOCKS  valid blocks; contiguous from bit 0.
- i_eop  in  1  qualifies the last data word.
- i_length_block  in  NB_BLOCK  len(A)||len(C); sampled with i_eop.
- o_hpow_ready  out  1  power table valid.
- o_busy  out  1  message in progress (ACCUM or LEN state).
- o_ghash  out  NB_BLOCK  final GHASH value.
- o_ghash_valid  out  1  one-cycle strobe with o_ghash.
- o_fault_sop_during_key  out  1  sticky; cleared only by reset.

Behaviour:
- Arithmetic: GCM GF(2^128) multiply with bit 0 = MSB, reduction R = E1||0^120. The existing gf multiplier is reused per lane.
- Reset values: all outputs 0; table entries 0; accumulator Y = 0; state NOKEY.
- FSM states: NOKEY, KEYEXP, READY, ACCUM, LEN.
- i_update_key, any state → KEYEXP:
  - H^1 = i_h_key loaded that cycle; o_hpow_ready drops next cycle.
  - One power per enabled cycle: H^(j+1) = H^j·H.
  - After N_BLOCKS-1 enabled cycles → READY, o_hpow_ready=1. If N_BLOCKS=1, READY on the next cycle.
  - i_update_key during ACCUM/LEN aborts the message; no o_ghash_valid.
- READY + i_sop → ACCUM, Y=0. The sop word may carry data: with i_data_valid, it is absorbed against Y=0.
- Absorb rule, word with k = popcount(mask) valid blocks X0..X(k-1):
  - Y' = (Y^X0)·H^k ^ X1·H^(k-1) ^ ... ^ X(k-1)·H^1.
  - Update in one cycle; full throughput, one word per cycle.
  - mask = 0 with i_data_valid: no-op.
  - Non-contiguous mask: upper blocks beyond the first zero are ignored.
- i_eop (with or without data) → LEN. Next enabled cycle: Y'' = (Y'^L)·H^1.
  - o_ghash = Y'' and o_ghash_valid = 1 on the following cycle (registered).
  - Latency eop→valid = 2 enabled cycles. Then → READY.
  - o_ghash holds its value until the next result.
- i_sop while in ACCUM/LEN: current message is dropped, no strobe; Y=0, restart.
- i_sop while in KEYEXP or NOKEY: ignored; o_fault_sop_during_key set.
- i_sop and i_eop in the same cycle: single-word message.
- i_data_valid outside ACCUM (except a sop word): ignored.
- i_valid=0: FSM, table, Y and outputs frozen. o_ghash_valid is forced 0 while i_valid=0 and is not re-issued.
- Reset mid-operation: immediate return to NOKEY; table invalid.

Optional Feature:
- GHASH_LEN_CHECK_EN.
- Defined:
  - A 64-bit counter adds 128 per absorbed block, resetting at sop.
  - At eop, the counter is compared with len(A)+len(C) from i_length_block.
  - Extra output o_len_mismatch (1 bit) is updated together with o_ghash_valid; reset 0.
- Undefined: no counter and no port. Behaviour is otherwise identical.

Test Plan:
- Key update with H=acbef20579b4b8ebce889bac8732dad7, N_BLOCKS=2 → o_hpow_ready rises 2 cycles after i_update_key; H^2 = H·H.
- GCM test case 15 with the same H, sop word then eop word:
  - sop word: {643a8cdcbfe5c0c97598a2bd2555d1aa, 522dc1f099567d07f47f37a32a84427d}, mask=11.
  - eop word: {c5f61e6393ba7a0abcc9f662898015ad, 8cb08e48590dbb3da7b08b1056828838}, mask=11.
  - Length block L=0...0200.
  - Expected: o_ghash=4db870d37cb75fcb46097c36230d1612, o_ghash_valid exactly 2 cycles after eop.
- Same four blocks sent as 3 words with masks 01,11,01 → identical 4db870d3... result.
- i_sop asserted mid-message, then the test case 15 stream → only one strobe, value 4db870d3....
- i_sop during KEYEXP → ignored, fault flag=1 until reset. Async reset during ACCUM → all outputs 0 immediately, state NOKEY.
- With GHASH_LEN_CHECK_EN: test case 15 with L=...0180 → o_len_mismatch=1; with L=...0200 → 0.

Source files
------------

// File: rtl/ghash_n_blocks_stream.sv
// Streaming GHASH: absorbs N_BLOCKS 128-bit blocks per clock against an internally built H^1..H^N table.
// Optional `GHASH_LEN_CHECK_EN adds a bit counter and the o_len_mismatch output.

module ghash_gf_mult #(
    parameter int NB_BLOCK = 128
) (
    input  logic [NB_BLOCK-1:0] a,
    input  logic [NB_BLOCK-1:0] b,
    output logic [NB_BLOCK-1:0] p
);
    // GCM bit order: vector bit NB_BLOCK-1 is the x^0 coefficient.
    logic [NB_BLOCK-1:0] z;
    logic [NB_BLOCK-1:0] v;

    always_comb begin
        z = '0;
        v = b;
        for (int i = NB_BLOCK - 1; i >= 0; i--) begin
            if (a[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, {(NB_BLOCK-8){1'b0}}}) : (v >> 1);
        end
        p = z;
    end
endmodule

module ghash_n_blocks_stream #(
    parameter int NB_BLOCK      = 128,
    parameter int N_BLOCKS      = 2,
    parameter int LOG2_N_BLOCKS = 1,
    parameter int NB_DATA       = N_BLOCKS * NB_BLOCK
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BLOCK-1:0] i_h_key,
    input  logic                i_update_key,
    input  logic                i_valid,
    input  logic                i_sop,
    input  logic                i_data_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic [N_BLOCKS-1:0] i_block_mask,
    input  logic                i_eop,
    input  logic [NB_BLOCK-1:0] i_length_block,
    output logic                o_hpow_ready,
    output logic                o_busy,
    output logic [NB_BLOCK-1:0] o_ghash,
    output logic                o_ghash_valid,
`ifdef GHASH_LEN_CHECK_EN
    output logic                o_len_mismatch,
`endif
    output logic                o_fault_sop_during_key
);
    localparam int CNT_W = $clog2(N_BLOCKS + 1);

    typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ACCUM, LEN} state_t;
    state_t state, state_nxt;

    logic [N_BLOCKS-1:0][NB_BLOCK-1:0] hpow;
    logic [N_BLOCKS-1:0][NB_BLOCK-1:0] lane_a, lane_b, lane_p;
    logic [LOG2_N_BLOCKS-1:0]          kidx;
    logic [NB_BLOCK-1:0]               y, y_base, y_abs, len_blk, len_p, tbl_a, tbl_p;
    logic [CNT_W-1:0]                  n_blk;
    logic                              run, key_done, ghash_vld;
    logic                              msg_state, sop_ok, sop_bad, absorb, eop_ok, finish;

    assign msg_state = (state == READY) || (state == ACCUM) || (state == LEN);
    assign sop_ok    = i_sop && msg_state && !i_update_key;
    assign sop_bad   = i_sop && ((state == NOKEY) || (state == KEYEXP));
    assign absorb    = i_data_valid && (sop_ok || (state == ACCUM && !i_update_key));
    assign eop_ok    = i_eop && (sop_ok || (state == ACCUM && !i_update_key));
    assign finish    = (state == LEN) && !i_sop && !i_update_key;
    assign key_done  = int'(kidx) >= N_BLOCKS - 1;
    assign y_base    = sop_ok ? '0 : y;

    assign o_busy        = (state == ACCUM) || (state == LEN);
    assign o_ghash_valid = ghash_vld & i_valid;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)      state <= NOKEY;
        else if (i_valid) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_update_key) state_nxt = KEYEXP;
        else begin
            case (state)
                KEYEXP:     if (key_done) state_nxt = READY;
                READY, LEN: if (i_sop) state_nxt = i_eop ? LEN : ACCUM;
                            else if (state == LEN) state_nxt = READY;
                ACCUM:      if (i_eop) state_nxt = LEN;
                default:    state_nxt = state;
            endcase
        end
    end

    // Valid block count is the run of ones from bit 0; anything past the first zero is dropped.
    always_comb begin
        n_blk = '0;
        run   = 1'b1;
        for (int j = 0; j < N_BLOCKS; j++) begin
            run = run & i_block_mask[j];
            if (run) n_blk = n_blk + 1'b1;
        end
    end

    // Block j of a k-block word is weighted by H^(k-j); block 0 also carries Y.
    always_comb begin
        for (int j = 0; j < N_BLOCKS; j++) begin
            lane_a[j] = i_data[j*NB_BLOCK +: NB_BLOCK] ^ ((j == 0) ? y_base : '0);
            lane_b[j] = '0;
            for (int p = 0; p < N_BLOCKS; p++)
                if (p == int'(n_blk) - 1 - j) lane_b[j] = hpow[p];
        end
    end

    always_comb begin
        y_abs = y_base;
        if (n_blk != '0) begin
            y_abs = '0;
            for (int j = 0; j < N_BLOCKS; j++) y_abs = y_abs ^ lane_p[j];
        end
    end

    always_comb begin
        tbl_a = '0;
        for (int p = 0; p < N_BLOCKS; p++)
            if (p == int'(kidx) - 1) tbl_a = hpow[p];
    end

    for (genvar g = 0; g < N_BLOCKS; g++) begin : g_lane
        ghash_gf_mult #(.NB_BLOCK(NB_BLOCK)) u_mult (.a(lane_a[g]), .b(lane_b[g]), .p(lane_p[g]));
    end

    ghash_gf_mult #(.NB_BLOCK(NB_BLOCK)) u_tbl (.a(tbl_a), .b(hpow[0]), .p(tbl_p));
    ghash_gf_mult #(.NB_BLOCK(NB_BLOCK)) u_len (.a(y ^ len_blk), .b(hpow[0]), .p(len_p));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hpow                   <= '0;
            kidx                   <= '0;
            o_hpow_ready           <= 1'b0;
            y                      <= '0;
            len_blk                <= '0;
            o_ghash                <= '0;
            ghash_vld              <= 1'b0;
            o_fault_sop_during_key <= 1'b0;
        end else if (!i_valid) begin
            // A pending strobe swallowed by a stall is never replayed.
            ghash_vld <= 1'b0;
        end else begin
            ghash_vld <= 1'b0;
            if (sop_bad) o_fault_sop_during_key <= 1'b1;
            if (i_update_key) begin
                hpow[0]      <= i_h_key;
                kidx         <= LOG2_N_BLOCKS'(1);
                o_hpow_ready <= 1'b0;
            end else begin
                if (state == KEYEXP) begin
                    for (int p = 1; p < N_BLOCKS; p++)
                        if (p == int'(kidx)) hpow[p] <= tbl_p;
                    if (key_done) o_hpow_ready <= 1'b1;
                    else          kidx <= kidx + 1'b1;
                end
                if (absorb)      y <= y_abs;
                else if (sop_ok) y <= '0;
                if (eop_ok) len_blk <= i_length_block;
                if (finish) begin
                    o_ghash   <= len_p;
                    ghash_vld <= 1'b1;
                end
            end
        end
    end

`ifdef GHASH_LEN_CHECK_EN
    logic [63:0] bit_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt        <= '0;
            o_len_mismatch <= 1'b0;
        end else if (i_valid) begin
            if (absorb)      bit_cnt <= (sop_ok ? 64'd0 : bit_cnt) + (64'(n_blk) << 7);
            else if (sop_ok) bit_cnt <= '0;
            if (finish) o_len_mismatch <= bit_cnt != (len_blk[127:64] + len_blk[63:0]);
        end
    end
`endif
endmodule
